preset_mode_reg: RTL

//  - Parametrised multi-mode register. It generalises the fixed 4-bit preset/set flop bank to WIDTH bits.
//  - Reset and set values are programmable parameters.
//  - Adds load, shift, rotate and up/down count modes, plus a registered wrap flag.
//  - Used as a general state/sequence register in control paths. Serial ports chain instances.

---
 rtl/preset_mode_reg_pkg.sv | 15 +
 rtl/preset_mode_reg_cell.sv | 16 +
 rtl/preset_mode_reg.sv | 83 ++++++++
 3 files changed

// File: rtl/preset_mode_reg_pkg.sv
// Shared definitions for preset_mode_reg: operation mode encodings and the mode type.
package preset_mode_reg_pkg;

  typedef logic [2:0] mode_e;

  localparam mode_e MODE_HOLD = 3'b000;
  localparam mode_e MODE_LOAD = 3'b001;
  localparam mode_e MODE_SHL  = 3'b010;
  localparam mode_e MODE_SHR  = 3'b011;
  localparam mode_e MODE_UP   = 3'b100;
  localparam mode_e MODE_DOWN = 3'b101;
  localparam mode_e MODE_ROL  = 3'b110;
  localparam mode_e MODE_ROR  = 3'b111;

endpackage

// File: rtl/preset_mode_reg_cell.sv
// Single storage bit with asynchronous active-low reset to a per-bit preset value.
module preset_mode_reg_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= RST_BIT;
    else          q <= d;
  end

endmodule

// File: rtl/preset_mode_reg.sv
// Multi-mode WIDTH-bit register: load, shift, rotate, up/down count with a registered wrap pulse.
// Optional even-parity output is built when PRESET_MODE_REG_PARITY_EN is defined.
module preset_mode_reg
  import preset_mode_reg_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(4'hD),
  parameter logic [WIDTH-1:0] SET_VAL = WIDTH'(4'h6)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             wrap
`ifdef PRESET_MODE_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Priority: set, then en=0 hold, then the selected mode.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (set) begin
      q_next = SET_VAL;
    end else if (en) begin
      case (mode)
        MODE_HOLD: q_next = q;
        MODE_LOAD: q_next = d;
        MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in};
        MODE_SHR:  q_next = {ser_in, q[WIDTH-1:1]};
        MODE_UP: begin
          q_next    = q + WIDTH'(1);
          wrap_next = &q;
        end
        MODE_DOWN: begin
          q_next    = q - WIDTH'(1);
          wrap_next = ~|q;
        end
        MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
        default:   q_next = q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    preset_mode_reg_cell #(
      .RST_BIT(RST_VAL[i])
    ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (q_next[i]),
      .q      (q[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap <= 1'b0;
    else          wrap <= wrap_next;
  end

`ifdef PRESET_MODE_REG_PARITY_EN
  // Registered from q_next so parity always tracks the current q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity <= ^RST_VAL;
    else          parity <= ^q_next;
  end
`endif

  // Left-moving modes all have mode[0]=0, so mode[0] alone picks the exiting end.
  assign ser_out = mode[0] ? q[0] : q[WIDTH-1];

endmodule
